bit_stuffer: RTL and testbench

Transmit-side USB bit stuffer: mirror of the receive-path unstuffer. It accepts a serial packet stream (sync, PID, payload, CRC) from the transmit CRC/encoder stage and inserts a 0 after every six consecutive 1s. It back-pressures upstream with `stall` for each inserted bit. The stuffed stream and its framing strobes go to the NRZI encoder.

---
 rtl/usb_tx_pkg.sv | 14 +
 rtl/bit_stuffer.sv | 118 +++++++++++
 tb/tb_bit_stuffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared USB transmit-path definitions: bit stuffer state encoding and defaults.
// The NRZI encoder and transmit CRC stage import this package as well.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STUFF,
        STUFF_LAST
    } stuff_state_t;

    localparam int unsigned STUFF_LIMIT_DEFAULT = 6;

endpackage

// File: rtl/bit_stuffer.sv
// Transmit-side USB bit stuffer. Inserts a 0 after every STUFF_LIMIT consecutive
// 1s, stalls upstream for one cycle per inserted bit, and re-times the packet
// framing strobes so they line up with the stuffed stream.
module bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int unsigned STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic s_in,
    input  logic start_stuffer,
    input  logic end_stuffer,
    output logic stall,
    output logic s_out,
    output logic start_nrzi,
    output logic end_nrzi
);

    // ones_cnt is 3 bits wide; STUFF_LIMIT must lie in 1..7.
    localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

    stuff_state_t state_q, state_d;
    logic [2:0]   ones_q, ones_d;
    logic         s_out_d, stall_d, start_d, end_d;

    logic         accept;
    logic [2:0]   ones_acc;
    logic         hit;

    // Decide whether an input bit is taken this cycle and what the run becomes.
    always_comb begin
        accept   = ((state_q == IDLE) && start_stuffer) || (state_q == SEND);
        // A new packet restarts the run count before counting its first bit.
        if (!s_in) begin
            ones_acc = 3'd0;
        end else if (state_q == IDLE) begin
            ones_acc = 3'd1;
        end else begin
            ones_acc = ones_q + 3'd1;
        end
        hit = accept && s_in && (ones_acc == LIMIT);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, SEND: begin
                if (accept) begin
                    if (hit) begin
                        state_d = end_stuffer ? STUFF_LAST : STUFF;
                    end else if (end_stuffer) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            STUFF:      state_d = SEND;
            STUFF_LAST: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the run counter.
    always_comb begin
        s_out_d = 1'b0;
        stall_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        ones_d  = ones_q;
        unique case (state_q)
            IDLE, SEND: begin
                if (accept) begin
                    s_out_d = s_in;
                    start_d = (state_q == IDLE);
                    ones_d  = ones_acc;
                    stall_d = hit;
                    // With a stuff pending, end_nrzi moves onto the stuffed 0.
                    end_d   = end_stuffer && !hit;
                end else begin
                    ones_d  = 3'd0;
                end
            end
            STUFF: begin
                ones_d = 3'd0;
            end
            STUFF_LAST: begin
                ones_d = 3'd0;
                end_d  = 1'b1;
            end
            default: begin
                ones_d = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ones_q     <= 3'd0;
            s_out      <= 1'b0;
            stall      <= 1'b0;
            start_nrzi <= 1'b0;
            end_nrzi   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            s_out      <= s_out_d;
            stall      <= stall_d;
            start_nrzi <= start_d;
            end_nrzi   <= end_d;
        end
    end

endmodule

// File: tb/tb_bit_stuffer.sv
// Self-checking bench for bit_stuffer: directed packets, random back-to-back
// packets, and asynchronous reset / abort behaviour.
module tb_bit_stuffer;
    import usb_tx_pkg::*;

    localparam int LIMIT = int'(STUFF_LIMIT_DEFAULT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_in = 1'b0;
    logic start_stuffer = 1'b0;
    logic end_stuffer = 1'b0;
    logic stall, s_out, start_nrzi, end_nrzi;

    int n_checks = 0;
    int n_fail = 0;

    // Input stream presented by the upstream model
    bit in_bits[$], in_start[$], in_end[$];
    // Expected stuffed stream
    bit exp_out[$], exp_start[$], exp_end[$], exp_stall[$];
    // Captured DUT outputs, one entry per cycle
    bit rec_out[$], rec_start[$], rec_end[$], rec_stall[$];

    always #5 clk = ~clk;

    bit_stuffer #(
        .STUFF_LIMIT(STUFF_LIMIT_DEFAULT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_in         (s_in),
        .start_stuffer(start_stuffer),
        .end_stuffer  (end_stuffer),
        .stall        (stall),
        .s_out        (s_out),
        .start_nrzi   (start_nrzi),
        .end_nrzi     (end_nrzi)
    );

    function automatic void clear_stream();
        in_bits.delete(); in_start.delete(); in_end.delete();
        exp_out.delete(); exp_start.delete(); exp_end.delete(); exp_stall.delete();
    endfunction

    // Reference: append a 0 after every LIMIT consecutive 1s; stall marks the
    // output slot carrying the 1 that completed the run.
    function automatic void add_packet(input bit pkt[$]);
        int run = 0;
        int n = pkt.size();
        for (int i = 0; i < n; i++) begin
            in_bits.push_back(pkt[i]);
            in_start.push_back(i == 0);
            in_end.push_back(i == n - 1);
            exp_out.push_back(pkt[i]);
            exp_start.push_back(i == 0);
            exp_end.push_back(1'b0);
            exp_stall.push_back(1'b0);
            run = pkt[i] ? run + 1 : 0;
            if (run == LIMIT) begin
                exp_stall[exp_stall.size() - 1] = 1'b1;
                exp_out.push_back(1'b0);
                exp_start.push_back(1'b0);
                exp_end.push_back(1'b0);
                exp_stall.push_back(1'b0);
                run = 0;
            end
        end
        exp_end[exp_end.size() - 1] = 1'b1;
    endfunction

    function automatic void add_pattern(input string pat);
        bit pkt[$];
        for (int i = 0; i < pat.len(); i++) pkt.push_back(pat.getc(i) == 8'h31);
        add_packet(pkt);
    endfunction

    task automatic drive_inputs(input int idx);
        if (idx < in_bits.size()) begin
            s_in = in_bits[idx];
            start_stuffer = in_start[idx];
            end_stuffer = in_end[idx];
        end else begin
            s_in = 1'b0;
            start_stuffer = 1'b0;
            end_stuffer = 1'b0;
        end
    endtask

    // Upstream model: present bit idx, advance only when stall was low at the edge.
    task automatic run_stream();
        int idx = 0;
        int ncyc = exp_out.size() + 2;
        bit st;
        rec_out.delete(); rec_start.delete(); rec_end.delete(); rec_stall.delete();
        @(negedge clk);
        drive_inputs(idx);
        repeat (ncyc) begin
            st = stall;
            @(posedge clk);
            if (!st && idx < in_bits.size()) idx++;
            @(negedge clk);
            rec_out.push_back(s_out);
            rec_start.push_back(start_nrzi);
            rec_end.push_back(end_nrzi);
            rec_stall.push_back(stall);
            drive_inputs(idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_out, stall, start_nrzi, end_nrzi} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got out/stall/start/end=%b%b%b%b expected 0000",
                     s_out, stall, start_nrzi, end_nrzi);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({s_out, stall, start_nrzi, end_nrzi} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle: got out/stall/start/end=%b%b%b%b expected 0000",
                         s_out, stall, start_nrzi, end_nrzi);
            end
        end
        // Start a packet of 1s, then reset asynchronously between clock edges.
        s_in = 1'b1;
        start_stuffer = 1'b1;
        @(negedge clk);
        start_stuffer = 1'b0;
        n_checks++;
        if ({s_out, start_nrzi} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_pre: got out/start=%b%b expected 11", s_out, start_nrzi);
        end
        #1 rst = 1'b1;
        s_in = 1'b0;
        #1;
        n_checks++;
        if ({s_out, stall, start_nrzi, end_nrzi} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: got out/stall/start/end=%b%b%b%b expected 0000",
                     s_out, stall, start_nrzi, end_nrzi);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        string pats[7] = '{"00000001", "111111111", "0111111", "11111011111",
                           "111111111111", "1", "0"};
        for (int k = 0; k < 7; k++) begin
            clear_stream();
            add_pattern(pats[k]);
            run_stream();
            for (int i = 0; i < rec_out.size(); i++) begin
                bit eo  = (i < exp_out.size()) ? exp_out[i] : 1'b0;
                bit es  = (i < exp_out.size()) ? exp_start[i] : 1'b0;
                bit ee  = (i < exp_out.size()) ? exp_end[i] : 1'b0;
                bit est = (i < exp_out.size()) ? exp_stall[i] : 1'b0;
                n_checks++;
                if ({rec_out[i], rec_start[i], rec_end[i], rec_stall[i]} !== {eo, es, ee, est}) begin
                    n_fail++;
                    $display("FAIL directed %s cycle %0d: got out/start/end/stall=%b%b%b%b expected %b%b%b%b",
                             pats[k], i, rec_out[i], rec_start[i], rec_end[i], rec_stall[i],
                             eo, es, ee, est);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 6; g++) begin
            int npkt = $urandom_range(5, 2);
            clear_stream();
            for (int p = 0; p < npkt; p++) begin
                bit pkt[$];
                int len = $urandom_range(30, 1);
                for (int b = 0; b < len; b++) pkt.push_back($urandom_range(3, 0) != 0);
                add_packet(pkt);
            end
            run_stream();
            for (int i = 0; i < rec_out.size(); i++) begin
                bit eo  = (i < exp_out.size()) ? exp_out[i] : 1'b0;
                bit es  = (i < exp_out.size()) ? exp_start[i] : 1'b0;
                bit ee  = (i < exp_out.size()) ? exp_end[i] : 1'b0;
                bit est = (i < exp_out.size()) ? exp_stall[i] : 1'b0;
                n_checks++;
                if ({rec_out[i], rec_start[i], rec_end[i], rec_stall[i]} !== {eo, es, ee, est}) begin
                    n_fail++;
                    $display("FAIL back_to_back group %0d cycle %0d: got out/start/end/stall=%b%b%b%b expected %b%b%b%b",
                             g, i, rec_out[i], rec_start[i], rec_end[i], rec_stall[i],
                             eo, es, ee, est);
                end
            end
        end
    endtask

    task automatic test_abort();
        int idx = 0;
        int cyc = 0;
        bit seen = 1'b0;
        bit st;
        @(negedge clk);
        while (!seen && cyc < 20) begin
            s_in = 1'b1;
            start_stuffer = (idx == 0);
            end_stuffer = (idx == 11);
            st = stall;
            @(posedge clk);
            if (!st) idx++;
            @(negedge clk);
            cyc++;
            seen = stall;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL abort_stall_seen: got no stall within 20 cycles, expected one");
        end
        // Stuff cycle in progress: reset mid-cycle.
        #1 rst = 1'b1;
        s_in = 1'b0;
        start_stuffer = 1'b0;
        end_stuffer = 1'b0;
        #1;
        n_checks++;
        if ({s_out, stall, start_nrzi, end_nrzi} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_async: got out/stall/start/end=%b%b%b%b expected 0000",
                     s_out, stall, start_nrzi, end_nrzi);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if ({s_out, end_nrzi, stall} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_no_end: got out/end/stall=%b%b%b expected 000",
                         s_out, end_nrzi, stall);
            end
        end
        clear_stream();
        add_pattern("00000001");
        run_stream();
        for (int i = 0; i < rec_out.size(); i++) begin
            bit eo  = (i < exp_out.size()) ? exp_out[i] : 1'b0;
            bit es  = (i < exp_out.size()) ? exp_start[i] : 1'b0;
            bit ee  = (i < exp_out.size()) ? exp_end[i] : 1'b0;
            bit est = (i < exp_out.size()) ? exp_stall[i] : 1'b0;
            n_checks++;
            if ({rec_out[i], rec_start[i], rec_end[i], rec_stall[i]} !== {eo, es, ee, est}) begin
                n_fail++;
                $display("FAIL abort_followup cycle %0d: got out/start/end/stall=%b%b%b%b expected %b%b%b%b",
                         i, rec_out[i], rec_start[i], rec_end[i], rec_stall[i], eo, es, ee, est);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
